program_loader: RTL and testbench

Streams a program image and initial data into the single-cycle CPU's instruction memory, data memory and register file over a 32-bit valid/ready word stream, then releases the CPU. It is the write side of the CPU's architectural state, complementing the bench-side monitor that reads PC, data memory and registers every cycle. It sits between the host/bench stream and the CPU's memory and register-file write ports, and drives the CPU start signal.

---
 rtl/program_loader.sv | 147 ++++++++++++++
 tb/tb_program_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams headers and payload words into CPU instruction/data memory and register file.
// Holds the CPU idle until an END header arrives; only reset leaves RUN.
module program_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [31:0]       in_data_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [1:0]        wr_sel_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              cpu_start_o,
  output logic [15:0]       words_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]        r_sel;
  logic [13:0]       r_count;
  logic [ADDR_W-1:0] r_addr;

  logic              r_ready;
  logic              r_wr_en;
  logic              r_start;
  logic [1:0]        r_wr_sel;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [15:0]       r_words;

  logic              w_xfer;
  logic [1:0]        w_hdr_t;
  logic [13:0]       w_hdr_n;
  logic [ADDR_W-1:0] w_hdr_addr;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_latch;
  logic              w_wr_en_nxt;
  logic              w_ready_nxt;
  logic              w_start_nxt;

  assign w_xfer  = in_valid_i & r_ready;
  assign w_hdr_t = in_data_i[31:30];
  assign w_hdr_n = in_data_i[29:16];

  // Register-file loads live in a 32-entry space, so their address is kept 5 bits wide throughout.
  assign w_hdr_addr = (w_hdr_t == 2'd2) ? {{(ADDR_W-5){1'b0}}, in_data_i[4:0]}
                                        : in_data_i[ADDR_W-1:0];
  assign w_addr_inc = (r_sel == 2'd2) ? {{(ADDR_W-5){1'b0}}, r_addr[4:0] + 5'd1}
                                      : r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_hdr_t == 2'd3) begin
            w_state_nxt = S_RUN;
          end else if (w_hdr_n != 14'd0) begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_xfer && (r_count == 14'd1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_latch     = 1'b0;
    w_wr_en_nxt = 1'b0;
    w_ready_nxt = 1'b1;
    w_start_nxt = 1'b0;
    if ((r_state == S_IDLE) && w_xfer && (w_hdr_t != 2'd3) && (w_hdr_n != 14'd0)) begin
      w_latch = 1'b1;
    end
    if ((r_state == S_LOAD) && w_xfer) begin
      w_wr_en_nxt = 1'b1;
    end
    if (w_state_nxt == S_RUN) begin
      w_ready_nxt = 1'b0;
      w_start_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel     <= 2'd0;
      r_count   <= 14'd0;
      r_addr    <= '0;
      r_ready   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_start   <= 1'b0;
      r_wr_sel  <= 2'd0;
      r_wr_addr <= '0;
      r_wr_data <= 32'd0;
      r_words   <= 16'd0;
    end else begin
      r_ready <= w_ready_nxt;
      r_start <= w_start_nxt;
      r_wr_en <= w_wr_en_nxt;
      if (w_latch) begin
        r_sel   <= w_hdr_t;
        r_count <= w_hdr_n;
        r_addr  <= w_hdr_addr;
      end
      if (w_wr_en_nxt) begin
        r_wr_sel  <= r_sel;
        r_wr_addr <= r_addr;
        r_wr_data <= in_data_i;
        r_words   <= r_words + 16'd1;
        r_addr    <= w_addr_inc;
        r_count   <= r_count - 14'd1;
      end
    end
  end

  assign in_ready_o  = r_ready;
  assign wr_en_o     = r_wr_en;
  assign wr_sel_o    = r_wr_sel;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign cpu_start_o = r_start;
  assign words_o     = r_words;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized bench for program_loader against a segment-level loader model.
// The model expands each header into its expected writes with base+k address arithmetic.
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_start;
  logic [15:0] words;

  program_loader #(.ADDR_W(10)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .wr_en_o    (wr_en),
    .wr_sel_o   (wr_sel),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .cpu_start_o(cpu_start),
    .words_o    (words)
  );

  typedef struct {
    int          due;
    logic [1:0]  sel;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 0;

  bit          m_ready = 0;
  bit          m_run = 0;
  int          m_left = 0;
  int          m_k = 0;
  int          m_t = 0;
  int          m_base = 0;
  logic [15:0] m_words = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      bit  exp_en;
      exp_en = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("wr_en", {63'd0, wr_en}, {63'd0, exp_en});
      if (exp_en) begin
        e = exp_q.pop_front();
        check("wr_sel",  {62'd0, wr_sel},  {62'd0, e.sel});
        check("wr_addr", {54'd0, wr_addr}, {54'd0, e.addr});
        check("wr_data", {32'd0, wr_data}, {32'd0, e.data});
      end else if ((exp_q.size() > 0) && (exp_q[0].due < cyc)) begin
        void'(exp_q.pop_front());
      end
      check("in_ready",  {63'd0, in_ready},  {63'd0, m_ready});
      check("cpu_start", {63'd0, cpu_start}, {63'd0, m_run});
    end
  end

  // Model of one accepted word: header decode or expansion of the current segment.
  task automatic model_word(input logic [31:0] w);
    wr_t e;
    int  a;
    if (!m_ready || m_run) return;
    if (m_left == 0) begin
      if (w[31:30] == 2'd3) begin
        m_run   = 1;
        m_ready = 0;
      end else if (w[29:16] != 14'd0) begin
        m_t    = int'(w[31:30]);
        m_left = int'(w[29:16]);
        m_base = int'(w[15:0]);
        m_k    = 0;
      end
    end else begin
      a = (m_t == 2) ? ((m_base + m_k) % 32) : ((m_base + m_k) % 1024);
      e.due  = cyc;
      e.sel  = 2'(m_t);
      e.addr = 10'(a);
      e.data = w;
      exp_q.push_back(e);
      m_k++;
      m_left--;
      m_words = m_words + 16'd1;
    end
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    model_word(w);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_words(input string tag);
    idle(2);
    check(tag, {48'd0, words}, {48'd0, m_words});
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    repeat (n) begin
      @(posedge clk); #1;
      m_ready = 0;
      m_run   = 0;
      m_left  = 0;
      m_words = 16'd0;
      mon_en  = 1;
      exp_q.delete();
    end
    @(negedge clk);
    check("rst_wr_sel",  {62'd0, wr_sel},  64'd0);
    check("rst_wr_addr", {54'd0, wr_addr}, 64'd0);
    check("rst_wr_data", {32'd0, wr_data}, 64'd0);
    check("rst_words",   {48'd0, words},   64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    m_ready = 1;
  endtask

  task automatic rand_segment();
    logic [1:0]  t;
    logic [13:0] n;
    logic [15:0] a;
    t = 2'($urandom_range(0, 2));
    n = 14'($urandom_range(0, 6));
    a = 16'($urandom);
    if ($urandom_range(0, 2) == 0) a[9:0] = 10'($urandom_range(1018, 1023));
    if ($urandom_range(0, 2) == 0) a[4:0] = 5'($urandom_range(28, 31));
    send({t, n, a}, $urandom_range(0, 2));
    for (int i = 0; i < int'(n); i++) send($urandom, $urandom_range(0, 2));
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    @(posedge clk); #1;
    do_reset(2);

    send(32'h0003_0010, 0);
    send(32'h2001_0005, 0);
    send(32'h2002_0007, 0);
    send(32'h0022_1820, 0);
    check_words("words_iload");

    send(32'h4002_0000, 0);
    send(32'h0000_000A, 0);
    send(32'hFFFF_FFFF, 2);
    check_words("words_dload");

    send(32'h8003_001E, 0);
    send(32'h0000_0007, 0);
    send(32'h0000_0008, 0);
    send(32'h0000_0009, 0);
    send(32'h0000_0005, 0);
    check_words("words_regwrap");

    for (int s = 0; s < 12; s++) rand_segment();
    check_words("words_random");

    send(32'hC000_0000, 0);
    send(32'h0001_0000, 0);
    send(32'h1234_5678, 0);
    check_words("words_run");

    for (int r = 0; r < 3; r++) begin
      do_reset(1 + r % 2);
      for (int s = 0; s < 6; s++) rand_segment();
      send(32'h0003_0000, 0);
      send($urandom, 0);
      do_reset(1);
      check_words("words_midload");
      send(32'hC000_0000, 0);
      idle(1);
      send(32'h0002_0000, 0);
      check_words("words_after_end");
    end

    idle(2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
